// File: rtl/snitch_icache_lookup_multiway.sv
// L1 instruction-cache lookup stage: N-way flop tag/data store, way-selective flush sweep,
// write-vs-lookup starvation guard, multi-hit detection and a 2-stage elastic result pipeline.
module snitch_icache_lookup_multiway #(
    parameter int unsigned FETCH_AW     = 48,
    parameter int unsigned LINE_WIDTH   = 128,
    parameter int unsigned LINE_COUNT   = 64,
    parameter int unsigned WAY_COUNT    = 4,
    parameter int unsigned ID_WIDTH     = 4,
    parameter int unsigned STARVE_LIMIT = 4,
    localparam int unsigned LINE_ALIGN  = $clog2(LINE_WIDTH / 8),
    localparam int unsigned COUNT_ALIGN = $clog2(LINE_COUNT),
    localparam int unsigned TAG_WIDTH   = FETCH_AW - LINE_ALIGN - COUNT_ALIGN,
    localparam int unsigned SET_ALIGN   = (WAY_COUNT > 1) ? $clog2(WAY_COUNT) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_valid_i,
    input  logic [WAY_COUNT-1:0]   flush_way_mask_i,
    output logic                   flush_ready_o,
    input  logic [FETCH_AW-1:0]    in_addr_i,
    input  logic [ID_WIDTH-1:0]    in_id_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    output logic [FETCH_AW-1:0]    out_addr_o,
    output logic [ID_WIDTH-1:0]    out_id_o,
    output logic [SET_ALIGN-1:0]   out_set_o,
    output logic                   out_hit_o,
    output logic [LINE_WIDTH-1:0]  out_data_o,
    output logic                   out_error_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    input  logic [COUNT_ALIGN-1:0] write_addr_i,
    input  logic [SET_ALIGN-1:0]   write_way_i,
    input  logic [LINE_WIDTH-1:0]  write_data_i,
    input  logic [TAG_WIDTH-1:0]   write_tag_i,
    input  logic                   write_error_i,
    input  logic                   write_valid_i,
    output logic                   write_ready_o
);
    localparam int unsigned SC_W = $clog2(STARVE_LIMIT + 2);

    typedef enum logic {ST_RUN, ST_SWEEP} state_t;

    state_t                 state_q;
    logic [COUNT_ALIGN-1:0] sweep_idx_q;
    logic [WAY_COUNT-1:0]   sweep_mask_q;
    logic [SC_W-1:0]        starve_cnt_q;

    logic [WAY_COUNT-1:0]  valid_q [LINE_COUNT];
    logic [WAY_COUNT-1:0]  error_q [LINE_COUNT];
    logic [TAG_WIDTH-1:0]  tag_q   [WAY_COUNT][LINE_COUNT];
    logic [LINE_WIDTH-1:0] data_q  [WAY_COUNT][LINE_COUNT];

    logic [WAY_COUNT-1:0]  rd_valid_q, rd_error_q;
    logic [TAG_WIDTH-1:0]  rd_tag_q  [WAY_COUNT];
    logic [LINE_WIDTH-1:0] rd_data_q [WAY_COUNT];

    logic                s1_valid_q;
    logic [FETCH_AW-1:0] s1_addr_q;
    logic [ID_WIDTH-1:0] s1_id_q;

    logic sweep, s1_adv, s1_free, force_lookup, write_grant, lookup_grant;
    logic [COUNT_ALIGN-1:0] in_set;

    assign sweep   = (state_q == ST_SWEEP);
    assign s1_adv  = s1_valid_q && (!out_valid_o || out_ready_i);
    assign s1_free = !s1_valid_q || s1_adv;
    assign in_set  = in_addr_i[LINE_ALIGN +: COUNT_ALIGN];

    // A lookup that has waited out STARVE_LIMIT write grants takes the port this cycle.
    assign force_lookup = (STARVE_LIMIT != 0) && (starve_cnt_q == SC_W'(STARVE_LIMIT))
                          && in_valid_i && s1_free && !sweep;

    assign flush_ready_o = !sweep;
    assign write_ready_o = !sweep && !force_lookup;
    assign in_ready_o    = !sweep && s1_free && (force_lookup || !write_valid_i);
    assign write_grant   = write_valid_i && write_ready_o && rst_ni;
    assign lookup_grant  = in_valid_i && in_ready_o && rst_ni;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= ST_SWEEP;
            sweep_idx_q  <= '0;
            sweep_mask_q <= '1;
        end else begin
            case (state_q)
                ST_SWEEP: begin
                    sweep_idx_q <= sweep_idx_q + COUNT_ALIGN'(1);
                    if (sweep_idx_q == COUNT_ALIGN'(LINE_COUNT - 1)) state_q <= ST_RUN;
                end
                default: begin
                    if (flush_valid_i) begin
                        state_q      <= ST_SWEEP;
                        sweep_idx_q  <= '0;
                        sweep_mask_q <= flush_way_mask_i;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || lookup_grant || !in_valid_i) begin
            starve_cnt_q <= '0;
        end else if (write_grant && s1_free && (starve_cnt_q < SC_W'(STARVE_LIMIT))) begin
            starve_cnt_q <= starve_cnt_q + SC_W'(1);
        end
    end

    // Single shared port: sweep, write and read are mutually exclusive by arbitration.
    always_ff @(posedge clk_i) begin
        if (sweep) begin
            valid_q[sweep_idx_q] <= valid_q[sweep_idx_q] & ~sweep_mask_q;
        end else if (write_grant) begin
            for (int w = 0; w < WAY_COUNT; w++) begin
                if (write_way_i == SET_ALIGN'(w)) begin
                    valid_q[write_addr_i][w] <= 1'b1;
                    error_q[write_addr_i][w] <= write_error_i;
                    tag_q[w][write_addr_i]   <= write_tag_i;
                    data_q[w][write_addr_i]  <= write_data_i;
                end
            end
        end else if (lookup_grant) begin
            rd_valid_q <= valid_q[in_set];
            rd_error_q <= error_q[in_set];
            for (int w = 0; w < WAY_COUNT; w++) begin
                rd_tag_q[w]  <= tag_q[w][in_set];
                rd_data_q[w] <= data_q[w][in_set];
            end
        end
    end

    logic [WAY_COUNT-1:0]  hit;
    logic                  found, sel_err;
    logic [SET_ALIGN-1:0]  sel_way;
    logic [LINE_WIDTH-1:0] sel_data;

    always_comb begin
        hit      = '0;
        found    = 1'b0;
        sel_way  = '0;
        sel_err  = 1'b0;
        sel_data = '0;
        for (int w = 0; w < WAY_COUNT; w++) begin
            hit[w] = rd_valid_q[w] && (rd_tag_q[w] == s1_addr_q[FETCH_AW-1 -: TAG_WIDTH]);
            if (hit[w] && !found) begin
                found    = 1'b1;
                sel_way  = SET_ALIGN'(w);
                sel_err  = rd_error_q[w];
                sel_data = rd_data_q[w];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_valid_q  <= 1'b0;
            s1_addr_q   <= '0;
            s1_id_q     <= '0;
            out_valid_o <= 1'b0;
            out_addr_o  <= '0;
            out_id_o    <= '0;
            out_set_o   <= '0;
            out_hit_o   <= 1'b0;
            out_data_o  <= '0;
            out_error_o <= 1'b0;
        end else begin
            if (lookup_grant) begin
                s1_valid_q <= 1'b1;
                s1_addr_q  <= in_addr_i;
                s1_id_q    <= in_id_i;
            end else if (s1_adv) begin
                s1_valid_q <= 1'b0;
            end
            if (s1_adv) begin
                out_valid_o <= 1'b1;
                out_addr_o  <= s1_addr_q;
                out_id_o    <= s1_id_q;
                out_set_o   <= sel_way;
                out_hit_o   <= found;
                out_data_o  <= sel_data;
                // hit & (hit-1) is nonzero exactly when more than one way hits
                out_error_o <= sel_err || (|(hit & (hit - WAY_COUNT'(1))));
            end else if (out_ready_i) begin
                out_valid_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_snitch_icache_lookup_multiway.sv
// Bench for snitch_icache_lookup_multiway: reference cache model feeding an expected-result queue,
// one task per scenario, plus a STARVE_LIMIT=0 instance sharing the same stimulus.
module tb_snitch_icache_lookup_multiway;
    localparam int RW = 48 + 4 + 2 + 1 + 1 + 128;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush_valid = 1'b0;
    logic [3:0]   flush_mask = '0;
    logic [47:0]  in_addr = '0;
    logic [3:0]   in_id = '0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [5:0]   write_addr = '0;
    logic [1:0]   write_way = '0;
    logic [127:0] write_data = '0;
    logic [37:0]  write_tag = '0;
    logic         write_error = 1'b0;
    logic         write_valid = 1'b0;

    logic         flush_ready, in_ready, out_hit, out_error, out_valid, write_ready;
    logic [47:0]  out_addr;
    logic [3:0]   out_id;
    logic [1:0]   out_set;
    logic [127:0] out_data;

    logic         b_flush_ready, b_in_ready, b_out_hit, b_out_error, b_out_valid, b_write_ready;
    logic [47:0]  b_out_addr;
    logic [3:0]   b_out_id;
    logic [1:0]   b_out_set;
    logic [127:0] b_out_data;

    always #5 clk = ~clk;

    snitch_icache_lookup_multiway dut (
        .clk_i(clk), .rst_ni(rst_n),
        .flush_valid_i(flush_valid), .flush_way_mask_i(flush_mask), .flush_ready_o(flush_ready),
        .in_addr_i(in_addr), .in_id_i(in_id), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .out_addr_o(out_addr), .out_id_o(out_id), .out_set_o(out_set), .out_hit_o(out_hit),
        .out_data_o(out_data), .out_error_o(out_error), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .write_addr_i(write_addr), .write_way_i(write_way), .write_data_i(write_data),
        .write_tag_i(write_tag), .write_error_i(write_error), .write_valid_i(write_valid),
        .write_ready_o(write_ready)
    );

    snitch_icache_lookup_multiway #(.STARVE_LIMIT(0)) dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .flush_valid_i(flush_valid), .flush_way_mask_i(flush_mask), .flush_ready_o(b_flush_ready),
        .in_addr_i(in_addr), .in_id_i(in_id), .in_valid_i(in_valid), .in_ready_o(b_in_ready),
        .out_addr_o(b_out_addr), .out_id_o(b_out_id), .out_set_o(b_out_set), .out_hit_o(b_out_hit),
        .out_data_o(b_out_data), .out_error_o(b_out_error), .out_valid_o(b_out_valid), .out_ready_i(out_ready),
        .write_addr_i(write_addr), .write_way_i(write_way), .write_data_i(write_data),
        .write_tag_i(write_tag), .write_error_i(write_error), .write_valid_i(write_valid),
        .write_ready_o(b_write_ready)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [RW-1:0] exp_q[$];

    logic         m_v    [4][64];
    logic         m_err  [4][64];
    logic [37:0]  m_tag  [4][64];
    logic [127:0] m_data [4][64];

    function automatic logic [47:0] mk_addr(input logic [37:0] tag, input int set);
        return {tag, 6'(set), 4'h3};
    endfunction

    function automatic logic [RW-1:0] exp_for(input logic [47:0] a, input logic [3:0] id);
        int s, nh;
        logic hit, err;
        logic [1:0] set;
        logic [127:0] d;
        s = int'(a[9:4]); nh = 0; hit = 0; err = 0; set = 0; d = '0;
        for (int w = 3; w >= 0; w--) begin
            if (m_v[w][s] && m_tag[w][s] == a[47:10]) begin
                nh++; hit = 1; set = 2'(w); err = m_err[w][s]; d = m_data[w][s];
            end
        end
        if (nh > 1) err = 1;
        return {a, id, set, hit, err, d};
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            logic [RW-1:0] got, e;
            got = {out_addr, out_id, out_set, out_hit, out_error, out_data};
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL result_unexpected: got %h expected none", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_err++;
                    $display("FAIL result: got %h expected %h", got, e);
                end
            end
        end
    end

    task automatic do_write(input int set, input int way, input logic [37:0] tag,
                            input logic [127:0] data, input logic err);
        int b = 0;
        write_valid = 1; write_addr = 6'(set); write_way = 2'(way);
        write_tag = tag; write_data = data; write_error = err;
        @(negedge clk);
        while (!write_ready && b < 200) begin @(negedge clk); b++; end
        n_vec++;
        if (!write_ready) begin
            n_err++;
            $display("FAIL write_timeout: ready %b expected 1", write_ready);
        end else if (way < 4) begin
            m_v[way][set] = 1; m_err[way][set] = err; m_tag[way][set] = tag; m_data[way][set] = data;
        end
        @(posedge clk); #1;
        write_valid = 0;
    endtask

    task automatic do_lookup(input logic [47:0] a, input logic [3:0] id);
        int b = 0;
        in_valid = 1; in_addr = a; in_id = id;
        @(negedge clk);
        while (!in_ready && b < 200) begin @(negedge clk); b++; end
        n_vec++;
        if (!in_ready) begin
            n_err++;
            $display("FAIL lookup_timeout: ready %b expected 1", in_ready);
        end else begin
            exp_q.push_back(exp_for(a, id));
        end
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic drain();
        int b = 0;
        while (exp_q.size() != 0 && b < 50) begin @(negedge clk); b++; end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d results outstanding expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic count_sweep(input string name);
        int cnt = 0;
        @(negedge clk);
        while (!flush_ready && cnt < 200) begin cnt++; @(negedge clk); end
        n_vec++;
        if (cnt != 64) begin
            n_err++;
            $display("FAIL %s: sweep cycles %0d expected 64", name, cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        int cnt = 0;
        for (int w = 0; w < 4; w++) for (int s = 0; s < 64; s++) m_v[w][s] = 0;
        rst_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({in_ready, write_ready, flush_ready, out_valid, out_hit, out_data} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b%b%b%b%b data %h expected all 0",
                     in_ready, write_ready, flush_ready, out_valid, out_hit, out_data);
        end
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        while (!in_ready && cnt < 200) begin cnt++; @(negedge clk); end
        n_vec++;
        if (cnt != 64) begin
            n_err++;
            $display("FAIL reset_sweep: in_ready low %0d cycles expected 64", cnt);
        end
        @(posedge clk); #1;
        do_lookup(mk_addr(38'h2bad, 17), 4'd9);
        do_lookup(mk_addr(38'h0, 0), 4'd10);
        drain();
    endtask

    task automatic test_hit();
        int b = 0;
        do_write(5, 2, 38'h1234, {16{8'hA5}}, 0);
        in_valid = 1; in_addr = mk_addr(38'h1234, 5); in_id = 4'd3;
        @(negedge clk);
        while (!in_ready && b < 200) begin @(negedge clk); b++; end
        exp_q.push_back(exp_for(in_addr, in_id));
        @(posedge clk); #1;
        in_valid = 0;
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL latency_early: out_valid %b expected 0", out_valid);
        end
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b1 || out_hit !== 1'b1 || out_set !== 2'd2) begin
            n_err++;
            $display("FAIL latency_hit: valid %b hit %b set %0d expected 1 1 2", out_valid, out_hit, out_set);
        end
        @(posedge clk); #1;
        drain();
        do_write(6, 0, 38'h66, {4{32'hdead_beef}}, 1);
        do_lookup(mk_addr(38'h66, 6), 4'd4);
        drain();
    endtask

    task automatic test_multi_hit();
        do_write(5, 1, 38'h1234, {8{16'h1111}}, 0);
        do_write(5, 3, 38'h1234, {8{16'h3333}}, 0);
        do_lookup(mk_addr(38'h1234, 5), 4'd5);
        drain();
    endtask

    task automatic test_flush();
        for (int w = 0; w < 4; w++) do_write(5, w, 38'h100 + 38'(w), {32{4'(w)}}, 0);
        flush_valid = 1; flush_mask = 4'b0100;
        write_valid = 1; write_addr = 6'd7; write_way = 2'd0; write_tag = 38'h77;
        write_data = {4{32'h7777_0000}}; write_error = 0;
        @(negedge clk);
        n_vec++;
        if (flush_ready !== 1'b1 || write_ready !== 1'b1) begin
            n_err++;
            $display("FAIL flush_write_same: flush_ready %b write_ready %b expected 1 1", flush_ready, write_ready);
        end else begin
            m_v[0][7] = 1; m_err[0][7] = 0; m_tag[0][7] = 38'h77; m_data[0][7] = {4{32'h7777_0000}};
            for (int s = 0; s < 64; s++) m_v[2][s] = 0;
        end
        @(posedge clk); #1;
        flush_valid = 0; write_valid = 0;
        count_sweep("flush_sweep");
        do_lookup(mk_addr(38'h102, 5), 4'd6);
        do_lookup(mk_addr(38'h100, 5), 4'd7);
        do_lookup(mk_addr(38'h101, 5), 4'd8);
        do_lookup(mk_addr(38'h77, 7), 4'd9);
        drain();
        flush_valid = 1; flush_mask = 4'b0000;
        @(posedge clk); #1;
        flush_valid = 0;
        count_sweep("flush_noop");
        do_lookup(mk_addr(38'h103, 5), 4'd1);
        drain();
    endtask

    task automatic test_hazard();
        do_lookup(mk_addr(38'h101, 5), 4'd2);
        do_write(5, 1, 38'h555, {16{8'h55}}, 0);
        do_lookup(mk_addr(38'h555, 5), 4'd3);
        drain();
    endtask

    task automatic test_starve();
        int b_lg = 0, b_wg = 0;
        logic wg, lg;
        out_ready = 1;
        write_valid = 1; write_addr = 6'd9; write_way = 2'd0; write_tag = 38'h999;
        write_data = {4{32'h9999_9999}}; write_error = 0;
        in_valid = 1; in_addr = mk_addr(38'h100, 5); in_id = 4'd0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            wg = write_valid && write_ready;
            lg = in_valid && in_ready;
            if (b_in_ready && in_valid) b_lg++;
            if (b_write_ready && write_valid) b_wg++;
            n_vec++;
            if ({wg, lg} !== ((k % 5 == 4) ? 2'b01 : 2'b10)) begin
                n_err++;
                $display("FAIL starve_pattern: cycle %0d write/lookup %b%b expected %b", k, wg, lg,
                         (k % 5 == 4) ? 2'b01 : 2'b10);
            end
            if (wg) begin
                m_v[0][9] = 1; m_err[0][9] = 0; m_tag[0][9] = 38'h999; m_data[0][9] = {4{32'h9999_9999}};
            end
            if (lg) exp_q.push_back(exp_for(in_addr, in_id));
            @(posedge clk); #1;
            if (lg) in_id++;
        end
        write_valid = 0; in_valid = 0;
        n_vec++;
        if (b_lg != 0 || b_wg != 20) begin
            n_err++;
            $display("FAIL starve_zero_limit: lookups %0d writes %0d expected 0 20", b_lg, b_wg);
        end
        drain();
    endtask

    task automatic test_backpressure();
        int acc = 0, b = 0;
        logic took, have = 0;
        logic [3:0] held_id = '0;
        logic [127:0] held_data = '0;
        out_ready = 0;
        in_valid = 1; in_addr = mk_addr(38'h100, 5); in_id = 4'd1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            took = in_valid && in_ready;
            if (took) begin exp_q.push_back(exp_for(in_addr, in_id)); acc++; end
            if (out_valid) begin
                n_vec++;
                if (!have) begin
                    if (out_id !== 4'd1) begin
                        n_err++;
                        $display("FAIL bp_first_id: got %0d expected 1", out_id);
                    end
                    held_id = 4'd1; held_data = out_data; have = 1;
                end else if ({out_id, out_data} !== {held_id, held_data}) begin
                    n_err++;
                    $display("FAIL bp_stable: got %0d %h expected %0d %h", out_id, out_data, held_id, held_data);
                end
            end
            if (c == 4) begin
                n_vec++;
                if (in_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL bp_ready: in_ready %b expected 0", in_ready);
                end
            end
            @(posedge clk); #1;
            if (took) begin in_id++; if (acc == 3) in_valid = 0; end
        end
        n_vec++;
        if (acc != 2) begin
            n_err++;
            $display("FAIL bp_accepts: got %0d expected 2", acc);
        end
        out_ready = 1;
        while (acc < 3 && b < 20) begin
            @(negedge clk);
            took = in_valid && in_ready;
            if (took) begin exp_q.push_back(exp_for(in_addr, in_id)); acc++; end
            @(posedge clk); #1;
            if (took) in_valid = 0;
            b++;
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_hit();
        test_multi_hit();
        test_flush();
        test_hazard();
        test_starve();
        test_backpressure();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached expected completion");
        $fatal(1, "watchdog");
    end
endmodule
